// File: rtl/spirxdata_if.sv
// spirxdata_if: block-read request/status, buffer write port and low-level byte link
// Revision: 1.0
`default_nettype none

interface spirxdata_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          i_start;
  logic [3:0]    i_lgblksz;
  logic          i_fifo;
  logic          o_busy;
  logic          o_write;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic          o_ll_stb;
  logic          i_ll_busy;
  logic          i_ll_stb;
  logic [7:0]    i_ll_byte;
  logic          o_done;
  logic [7:0]    o_response;
  logic          o_crcerr;
  logic          o_timeout;

  modport slave (
    input  i_start, i_lgblksz, i_fifo, i_ll_busy, i_ll_stb, i_ll_byte,
    output o_busy, o_write, o_addr, o_data, o_ll_stb, o_done,
           o_response, o_crcerr, o_timeout
  );

  modport master (
    output i_start, i_lgblksz, i_fifo, i_ll_busy, i_ll_stb, i_ll_byte,
    input  o_busy, o_write, o_addr, o_data, o_ll_stb, o_done,
           o_response, o_crcerr, o_timeout
  );
endinterface

`default_nettype wire

// File: rtl/spirxdata.sv
// spirxdata: SD/MMC SPI block-read receiver; waits for the start token, packs data bytes into words, checks CRC-16
// Revision: 1.0
`default_nettype none

module spirxdata #(
  parameter int DW                = 32,
  parameter int AW                = 8,
  parameter int OPT_LITTLE_ENDIAN = 0,
  parameter int LGTIMEOUT         = 16
) (
  input  wire logic   i_clk,
  input  wire logic   i_reset,
  spirxdata_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TOKEN = 2'd1,
    S_DATA  = 2'd2,
    S_CRC   = 2'd3
  } state_t;

  localparam logic [LGTIMEOUT-1:0] TOK_ONE  = {{(LGTIMEOUT-1){1'b0}}, 1'b1};
  localparam logic [AW-2:0]        ADDR_ONE = {{(AW-2){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [3:0]           lgblksz_q, lgblksz_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        data_q, data_d;
  logic                 write_q, write_d;
  logic                 done_q, done_d;
  logic [7:0]           resp_q, resp_d;
  logic                 crcerr_q, crcerr_d;
  logic                 timeout_q, timeout_d;
  logic [15:0]          crc_q, crc_d;
  logic [7:0]           rxcrc_q, rxcrc_d;
  logic                 crc2_q, crc2_d;
  logic                 pending_q, pending_d;
  logic [9:0]           remaining_q, remaining_d;
  logic [9:0]           bytecnt_q, bytecnt_d;
  logic [LGTIMEOUT-1:0] tokcnt_q, tokcnt_d;

  logic       ll_stb;
  logic       issue;
  logic       rx;
  logic [9:0] blkbytes;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // Only one token request may be in flight; data requests may stream back-to-back.
  always_comb begin
    ll_stb = 1'b0;
    case (state_q)
      S_TOKEN:      ll_stb = !pending_q;
      S_DATA, S_CRC: ll_stb = (remaining_q != 10'd0);
      default:      ll_stb = 1'b0;
    endcase
  end

  assign issue    = ll_stb && !bus.i_ll_busy;
  assign rx       = bus.i_ll_stb && (state_q != S_IDLE);
  assign blkbytes = 10'd1 << lgblksz_q;

  always_comb begin
    state_d     = state_q;
    lgblksz_d   = lgblksz_q;
    addr_d      = addr_q;
    data_d      = data_q;
    write_d     = 1'b0;
    done_d      = 1'b0;
    resp_d      = resp_q;
    crcerr_d    = crcerr_q;
    timeout_d   = timeout_q;
    crc_d       = crc_q;
    rxcrc_d     = rxcrc_q;
    crc2_d      = crc2_q;
    pending_d   = pending_q;
    remaining_d = remaining_q;
    bytecnt_d   = bytecnt_q;
    tokcnt_d    = tokcnt_q;

    if (write_q) addr_d = {addr_q[AW-1], addr_q[AW-2:0] + ADDR_ONE};

    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d     = S_TOKEN;
          lgblksz_d   = bus.i_lgblksz;
          addr_d      = {bus.i_fifo, {(AW-1){1'b0}}};
          crc_d       = 16'h0000;
          bytecnt_d   = 10'd0;
          tokcnt_d    = '0;
          crcerr_d    = 1'b0;
          timeout_d   = 1'b0;
          resp_d      = 8'h00;
          pending_d   = 1'b0;
          remaining_d = 10'd0;
          crc2_d      = 1'b0;
        end
      end

      S_TOKEN: begin
        // A reply in the issuing cycle answers that very request.
        pending_d = (pending_q | issue) & ~bus.i_ll_stb;
        if (rx) begin
          if (bus.i_ll_byte == 8'hFE) begin
            state_d     = S_DATA;
            remaining_d = blkbytes + 10'd2;
          end else if (bus.i_ll_byte[7:4] == 4'h0 && bus.i_ll_byte != 8'h00) begin
            resp_d  = bus.i_ll_byte;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (&tokcnt_q) begin
            timeout_d = 1'b1;
            done_d    = 1'b1;
            state_d   = S_IDLE;
          end else begin
            tokcnt_d = tokcnt_q + TOK_ONE;
          end
        end
      end

      S_DATA: begin
        if (issue) remaining_d = remaining_q - 10'd1;
        if (rx) begin
          if (OPT_LITTLE_ENDIAN != 0) data_d = {bus.i_ll_byte, data_q[DW-1:8]};
          else                        data_d = {data_q[DW-9:0], bus.i_ll_byte};
          crc_d     = crc16_byte(crc_q, bus.i_ll_byte);
          bytecnt_d = bytecnt_q + 10'd1;
          if (bytecnt_q[1:0] == 2'b11) write_d = 1'b1;
          if (bytecnt_q == blkbytes - 10'd1) state_d = S_CRC;
        end
      end

      S_CRC: begin
        if (issue) remaining_d = remaining_q - 10'd1;
        if (rx) begin
          if (!crc2_q) begin
            rxcrc_d = bus.i_ll_byte;
            crc2_d  = 1'b1;
          end else begin
            crcerr_d = ({rxcrc_q, bus.i_ll_byte} != crc_q);
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      lgblksz_q   <= 4'd0;
      addr_q      <= '0;
      data_q      <= '0;
      write_q     <= 1'b0;
      done_q      <= 1'b0;
      resp_q      <= 8'h00;
      crcerr_q    <= 1'b0;
      timeout_q   <= 1'b0;
      crc_q       <= 16'h0000;
      rxcrc_q     <= 8'h00;
      crc2_q      <= 1'b0;
      pending_q   <= 1'b0;
      remaining_q <= 10'd0;
      bytecnt_q   <= 10'd0;
      tokcnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      lgblksz_q   <= lgblksz_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      write_q     <= write_d;
      done_q      <= done_d;
      resp_q      <= resp_d;
      crcerr_q    <= crcerr_d;
      timeout_q   <= timeout_d;
      crc_q       <= crc_d;
      rxcrc_q     <= rxcrc_d;
      crc2_q      <= crc2_d;
      pending_q   <= pending_d;
      remaining_q <= remaining_d;
      bytecnt_q   <= bytecnt_d;
      tokcnt_q    <= tokcnt_d;
    end
  end

  assign bus.o_busy     = (state_q != S_IDLE);
  assign bus.o_ll_stb   = ll_stb;
  assign bus.o_write    = write_q;
  assign bus.o_addr     = addr_q;
  assign bus.o_data     = data_q;
  assign bus.o_done     = done_q;
  assign bus.o_response = resp_q;
  assign bus.o_crcerr   = crcerr_q;
  assign bus.o_timeout  = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_spirxdata.sv
// tb_spirxdata: directed checks of spirxdata with a scripted low-level byte responder
// Revision: 1.0
`default_nettype none

module tb_spirxdata;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spirxdata_if #(.AW(8), .DW(32)) bus ();

  spirxdata #(
    .DW(32), .AW(8), .OPT_LITTLE_ENDIAN(0), .LGTIMEOUT(4)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  rxq[$];
  logic [7:0]  blk[$];
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          issued;
  bit          rand_busy;
  bit          done_seen;
  logic        done_busy;
  logic [7:0]  done_resp;
  logic        done_crcerr;
  logic        done_timeout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Augmented-message polynomial division; equals CRC-16/XMODEM for a zero preset.
  function automatic logic [15:0] ref_crc();
    logic [15:0] r;
    logic        top;
    r = 16'h0000;
    for (int i = 0; i < blk.size() + 2; i++) begin
      for (int b = 7; b >= 0; b--) begin
        top = r[15];
        r   = {r[14:0], (i < blk.size()) ? blk[i][b] : 1'b0};
        if (top) r = r ^ 16'h1021;
      end
    end
    return r;
  endfunction

  // One cycle: observe registered outputs at the falling edge, then drive the link for the next rising edge.
  task automatic step();
    @(negedge clk);
    if (bus.o_write) begin
      wr_addr.push_back(bus.o_addr);
      wr_data.push_back(bus.o_data);
    end
    if (bus.o_done) begin
      done_seen    = 1'b1;
      done_busy    = bus.o_busy;
      done_resp    = bus.o_response;
      done_crcerr  = bus.o_crcerr;
      done_timeout = bus.o_timeout;
    end
    bus.i_ll_busy = rand_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
    if (bus.o_ll_stb && !bus.i_ll_busy) begin
      bus.i_ll_stb  = 1'b1;
      bus.i_ll_byte = (rxq.size() != 0) ? rxq.pop_front() : 8'hFF;
      issued++;
    end else begin
      bus.i_ll_stb  = 1'b0;
      bus.i_ll_byte = 8'h00;
    end
  endtask

  task automatic start_xfer(input logic [3:0] lg, input logic f);
    wr_addr.delete();
    wr_data.delete();
    done_seen     = 1'b0;
    issued        = 0;
    bus.i_lgblksz = lg;
    bus.i_fifo    = f;
    bus.i_start   = 1'b1;
    step();
    bus.i_start   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    for (int c = 0; c < maxc && !done_seen; c++) step();
    check({tag, "_done"}, {31'd0, done_seen}, 32'd1);
  endtask

  task automatic load_std(input bit flip);
    logic [15:0] c;
    blk.delete();
    for (int i = 1; i <= 8; i++) blk.push_back(8'(i));
    c = ref_crc();
    rxq.delete();
    rxq.push_back(8'hFF);
    rxq.push_back(8'hFF);
    rxq.push_back(8'hFE);
    foreach (blk[i]) rxq.push_back(blk[i]);
    rxq.push_back(c[15:8]);
    rxq.push_back(c[7:0] ^ (flip ? 8'h01 : 8'h00));
  endtask

  task automatic check_std(input string tag, input logic exp_crcerr);
    check({tag, "_nwrites"}, wr_addr.size(), 32'd2);
    if (wr_addr.size() == 2) begin
      check({tag, "_addr0"}, {24'd0, wr_addr[0]}, 32'h00);
      check({tag, "_data0"}, wr_data[0], 32'h01020304);
      check({tag, "_addr1"}, {24'd0, wr_addr[1]}, 32'h01);
      check({tag, "_data1"}, wr_data[1], 32'h05060708);
    end
    check({tag, "_crcerr"}, {31'd0, done_crcerr}, {31'd0, exp_crcerr});
    check({tag, "_resp"}, {24'd0, done_resp}, 32'h00);
    check({tag, "_busy_at_done"}, {31'd0, done_busy}, 32'd0);
    check({tag, "_requests"}, issued, 32'd13);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},    {31'd0, bus.o_busy},     32'd0);
    check({tag, "_ll_stb"},  {31'd0, bus.o_ll_stb},   32'd0);
    check({tag, "_write"},   {31'd0, bus.o_write},    32'd0);
    check({tag, "_done"},    {31'd0, bus.o_done},     32'd0);
    check({tag, "_addr"},    {24'd0, bus.o_addr},     32'd0);
    check({tag, "_data"},    bus.o_data,              32'd0);
    check({tag, "_resp"},    {24'd0, bus.o_response}, 32'd0);
    check({tag, "_crcerr"},  {31'd0, bus.o_crcerr},   32'd0);
    check({tag, "_timeout"}, {31'd0, bus.o_timeout},  32'd0);
  endtask

  initial begin
    logic [15:0] c;
    logic [31:0] w;
    int          nw;

    bus.i_start   = 1'b0;
    bus.i_lgblksz = 4'd3;
    bus.i_fifo    = 1'b0;
    bus.i_ll_busy = 1'b0;
    bus.i_ll_stb  = 1'b0;
    bus.i_ll_byte = 8'h00;
    rand_busy     = 1'b0;
    issued        = 0;

    // Reset state
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Good 8-byte block into buffer 0
    load_std(1'b0);
    start_xfer(4'd3, 1'b0);
    wait_done("good8", 200);
    check_std("good8", 1'b0);
    step();
    check("good8_busy_after", {31'd0, bus.o_busy}, 32'd0);
    check("good8_done_pulse", {31'd0, bus.o_done}, 32'd0);

    // Same block with a corrupted CRC byte
    load_std(1'b1);
    start_xfer(4'd3, 1'b0);
    wait_done("badcrc", 200);
    check_std("badcrc", 1'b1);

    // Error token
    rxq.delete();
    rxq.push_back(8'hFF);
    rxq.push_back(8'h05);
    start_xfer(4'd3, 1'b0);
    wait_done("errtok", 100);
    check("errtok_resp", {24'd0, done_resp}, 32'h05);
    check("errtok_nwrites", wr_addr.size(), 32'd0);
    check("errtok_busy_at_done", {31'd0, done_busy}, 32'd0);
    check("errtok_requests", issued, 32'd2);
    step();
    check("errtok_busy_after", {31'd0, bus.o_busy}, 32'd0);

    // Start-token timeout: 16 ignored 0xFF bytes
    rxq.delete();
    start_xfer(4'd3, 1'b0);
    wait_done("tmo", 100);
    check("tmo_timeout", {31'd0, done_timeout}, 32'd1);
    check("tmo_resp", {24'd0, done_resp}, 32'h00);
    check("tmo_nwrites", wr_addr.size(), 32'd0);
    check("tmo_requests", issued, 32'd16);
    for (int i = 0; i < 3; i++) step();
    check("tmo_hold_timeout", {31'd0, bus.o_timeout}, 32'd1);
    check("tmo_hold_done", {31'd0, bus.o_done}, 32'd0);

    // 512-byte block into buffer 1 with a stalling link
    blk.delete();
    for (int k = 0; k < 512; k++) blk.push_back(8'((k * 7 + 3) & 255));
    c = ref_crc();
    rxq.delete();
    rxq.push_back(8'hFE);
    foreach (blk[i]) rxq.push_back(blk[i]);
    rxq.push_back(c[15:8]);
    rxq.push_back(c[7:0]);
    rand_busy = 1'b1;
    start_xfer(4'd9, 1'b1);
    wait_done("big", 5000);
    rand_busy = 1'b0;
    check("big_nwrites", wr_addr.size(), 32'd128);
    check("big_post_token_requests", issued - 1, 32'd514);
    check("big_crcerr", {31'd0, done_crcerr}, 32'd0);
    nw = (wr_addr.size() < 128) ? wr_addr.size() : 128;
    for (int i = 0; i < nw; i++) begin
      w = {blk[4*i], blk[4*i+1], blk[4*i+2], blk[4*i+3]};
      check($sformatf("big_addr%0d", i), {24'd0, wr_addr[i]}, 32'h80 + 32'(i));
      check($sformatf("big_data%0d", i), wr_data[i], w);
    end

    // Reset in the middle of the data phase
    load_std(1'b0);
    void'(rxq.pop_front());
    void'(rxq.pop_front());
    start_xfer(4'd3, 1'b0);
    for (int cyc = 0; cyc < 50 && issued < 7; cyc++) step();
    check("midrst_progress", {31'd0, issued >= 7}, 32'd1);
    check("midrst_pre_writes", wr_addr.size(), 32'd1);
    #2;
    rst           = 1'b1;
    bus.i_ll_stb  = 1'b0;
    bus.i_ll_byte = 8'h00;
    #1;
    check_all_zero("midrst");
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("midrst_no_more_writes", wr_addr.size(), 32'd1);
    check("midrst_no_done", {31'd0, done_seen}, 32'd0);

    load_std(1'b0);
    start_xfer(4'd3, 1'b0);
    wait_done("after_rst", 200);
    check_std("after_rst", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
